// File: rtl/dcache_dm.sv
// Direct-mapped, write-through, no-write-allocate data cache with one word per line.
// Read hits return in one cycle; read misses and all writes go to backing memory
// over a req/ack handshake while busy stalls the core.
module dcache_dm #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned INDEX_W = 8,
  parameter int unsigned CNT_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              r_en,
  input  logic              w_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] w_data,
  output logic [DATA_W-1:0] r_data,
  output logic              r_valid,
  output logic              busy,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_w_data,
  input  logic [DATA_W-1:0] mem_r_data,
  input  logic              mem_ack,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic [CNT_W-1:0]  miss_cnt
);

  localparam int unsigned Lines = 2 ** INDEX_W;
  localparam int unsigned TagW  = ADDR_W - INDEX_W;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StFill  = 2'd1;
  localparam logic [1:0] StWrite = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [DATA_W-1:0] r_data_q, r_data_d;
  logic              r_valid_q, r_valid_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_w_data_q, mem_w_data_d;
  logic [CNT_W-1:0]  hit_cnt_q, hit_cnt_d;
  logic [CNT_W-1:0]  miss_cnt_q, miss_cnt_d;

  // Line storage; only the valid bits need a reset.
  logic [Lines-1:0]  valid_q;
  logic [TagW-1:0]   tag_mem  [Lines];
  logic [DATA_W-1:0] data_mem [Lines];

  logic [INDEX_W-1:0] req_idx;
  logic [TagW-1:0]    req_tag;
  logic               hit;

  logic               line_we;
  logic [INDEX_W-1:0] line_idx;
  logic [TagW-1:0]    line_tag;
  logic [DATA_W-1:0]  line_data;

  assign req_idx = addr[INDEX_W-1:0];
  assign req_tag = addr[ADDR_W-1:INDEX_W];
  assign hit     = valid_q[req_idx] && (tag_mem[req_idx] == req_tag);

  // Next-state, handshake and line-update decode.
  always_comb begin
    state_d      = state_q;
    r_data_d     = r_data_q;
    r_valid_d    = 1'b0;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_w_data_d = mem_w_data_q;
    hit_cnt_d    = hit_cnt_q;
    miss_cnt_d   = miss_cnt_q;
    line_we      = 1'b0;
    line_idx     = req_idx;
    line_tag     = req_tag;
    line_data    = w_data;

    case (state_q)
      StIdle: begin
        if (w_en) begin
          // Write-through: update only a resident line, always forward to memory.
          line_we      = hit;
          mem_addr_d   = addr;
          mem_w_data_d = w_data;
          mem_we_d     = 1'b1;
          mem_req_d    = 1'b1;
          state_d      = StWrite;
        end else if (r_en) begin
          if (hit) begin
            r_data_d  = data_mem[req_idx];
            r_valid_d = 1'b1;
            if (hit_cnt_q != '1) hit_cnt_d = hit_cnt_q + CNT_W'(1);
          end else begin
            mem_addr_d = addr;
            mem_we_d   = 1'b0;
            mem_req_d  = 1'b1;
            if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + CNT_W'(1);
            state_d    = StFill;
          end
        end
      end
      StFill: begin
        if (mem_ack) begin
          // Any conflicting line is simply overwritten; memory is always current.
          line_we   = 1'b1;
          line_idx  = mem_addr_q[INDEX_W-1:0];
          line_tag  = mem_addr_q[ADDR_W-1:INDEX_W];
          line_data = mem_r_data;
          r_data_d  = mem_r_data;
          r_valid_d = 1'b1;
          mem_req_d = 1'b0;
          state_d   = StIdle;
        end
      end
      StWrite: begin
        if (mem_ack) begin
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          state_d   = StIdle;
        end
      end
      default: begin
        mem_req_d = 1'b0;
        mem_we_d  = 1'b0;
        state_d   = StIdle;
      end
    endcase
  end

  // Control and handshake registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      r_data_q     <= '0;
      r_valid_q    <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_w_data_q <= '0;
      hit_cnt_q    <= '0;
      miss_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      r_data_q     <= r_data_d;
      r_valid_q    <= r_valid_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_w_data_q <= mem_w_data_d;
      hit_cnt_q    <= hit_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
    end
  end

  // Valid bits: cleared on reset, set whenever a line is written.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
    end else if (line_we) begin
      valid_q[line_idx] <= 1'b1;
    end
  end

  // Tag and data arrays carry no reset; valid_q gates their use.
  always_ff @(posedge clk) begin
    if (!reset && line_we) begin
      tag_mem[line_idx]  <= line_tag;
      data_mem[line_idx] <= line_data;
    end
  end

  assign r_data     = r_data_q;
  assign r_valid    = r_valid_q;
  assign busy       = (state_q != StIdle);
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_w_data = mem_w_data_q;
  assign hit_cnt    = hit_cnt_q;
  assign miss_cnt   = miss_cnt_q;

endmodule

// File: doc/dcache_dm.md
Name: dcache_dm

Overview:
Parametrised direct-mapped data cache. It replaces the flat scratch data RAM and sits between the core load/store stage and a slower backing data memory. Policy is write-through, no-write-allocate, one word per line. Misses and writes are forwarded over a req/ack handshake, and the core is stalled via busy.

Parameters:
DATA_W, 16, data word width in bits
ADDR_W, 16, word address width in bits
INDEX_W, 8, index bits; line count = 2**INDEX_W; legal range 1..ADDR_W-1
CNT_W, 16, width of hit/miss performance counters

Ports:
clk  input  1  clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
r_en  input  1  read request; sampled only when busy=0
w_en  input  1  write request; sampled only when busy=0; has priority over r_en
addr  input  ADDR_W  word address of request
w_data  input  DATA_W  write data
r_data  output  DATA_W  read data; holds last value until next read completes
r_valid  output  1  one-cycle pulse; r_data is valid in that cycle
busy  output  1  high while state != IDLE; core must hold and not issue requests
mem_req  output  1  backing memory request; held until mem_ack
mem_we  output  1  1 = write, 0 = read; stable while mem_req=1
mem_addr  output  ADDR_W  backing address; stable while mem_req=1
mem_w_data  output  DATA_W  backing write data; stable while mem_req=1
mem_r_data  input  DATA_W  backing read data; valid in the cycle mem_ack=1 on a read
mem_ack  input  1  one-cycle completion strobe; ignored when mem_req=0
hit_cnt  output  CNT_W  read hits since reset; saturates at all-ones
miss_cnt  output  CNT_W  read misses since reset; saturates at all-ones

Behaviour:
- Address split: index = addr[INDEX_W-1:0], tag = addr[ADDR_W-1:INDEX_W]. Storage per line: valid bit, tag, data.
- Reset (synchronous, reset=1 at an edge):
  - All valid bits cleared; state returns to IDLE.
  - r_data=0, r_valid=0, busy=0, mem_req=0, mem_we=0, mem_addr=0, mem_w_data=0, hit_cnt=0, miss_cnt=0.
  - Reset during FILL or WRITE aborts the transfer: mem_req is low in the cycle after the reset edge. A late mem_ack is ignored.
- Requests are accepted only in IDLE. In IDLE the lookup is combinational: hit = valid[index] && tag match.
- States: IDLE, FILL, WRITE.
- IDLE, w_en=1 (r_en ignored):
  - If hit, the line data is updated to w_data; a miss leaves the line untouched (no allocate).
  - Latch mem_addr=addr, mem_w_data=w_data, mem_we=1, mem_req=1; go to WRITE.
- IDLE, r_en=1, hit: next edge r_data=line data, r_valid=1, hit_cnt+1; stay IDLE. Read latency is 1 cycle and busy stays 0.
- IDLE, r_en=1, miss: latch mem_addr=addr, mem_we=0, mem_req=1, miss_cnt+1; go to FILL.
- FILL: wait for mem_ack. On the ack edge:
  - Line[index] gets valid=1, tag, data=mem_r_data.
  - r_data=mem_r_data, r_valid=1 in the following cycle.
  - mem_req=0; go to IDLE.
  - A conflicting tag is overwritten; no writeback is needed because the cache is write-through.
- WRITE: wait for mem_ack. On the ack edge mem_req=0, mem_we=0; go to IDLE. No r_valid pulse.
- mem_ack in the same cycle that mem_req is first raised is not possible: mem_req is registered, so the earliest ack is one cycle after the request appears.
- r_valid is 0 in every cycle not listed above.
- Counters saturate: when at all-ones they hold; there is no wrap.
- Back-to-back:
  - A new request is legal in the same cycle that r_valid pulses after a hit.
  - After FILL/WRITE completes, busy is 0 in the cycle following the ack edge, and a request is legal then.

Test Plan:
- Read miss: after reset, r_en addr=0x0012; memory acks 3 cycles after mem_req with 0xBEEF -> mem_req=1, mem_we=0, mem_addr=0x0012, busy=1; r_valid=1 with r_data=0xBEEF one cycle after ack; miss_cnt=1.
- Read hit: repeat r_en addr=0x0012 -> no mem_req, r_valid=1 next cycle with r_data=0xBEEF; hit_cnt=1; busy stays 0.
- Write hit, then no-allocate: w_en addr=0x0012 w_data=0x1234 -> mem_req=1, mem_we=1, mem_w_data=0x1234 held until ack; read 0x0012 then hits with 0x1234. w_en addr=0x0034 (miss) followed by a read of 0x0034 -> the read misses and issues mem_req.
- Conflict eviction: read 0x0112 (same index 0x12, tag 0x01) -> miss and fill with 0x5555; a following read of 0x0012 misses again; miss_cnt increments each time.
- Simultaneous r_en=1 and w_en=1, addr=0x0020 -> only a write transaction (mem_we=1); no r_valid; counters unchanged.
- Reset mid-FILL: assert reset while mem_req=1 -> mem_req=0 next cycle, busy=0, counters=0; a late mem_ack is ignored; the next read of the prior address misses.
